// File: rtl/fourier_bin_resp_64.sv
// ---------------------------------------------------------------------------
// fourier_bin_resp_64
//
// Computes two DFT bins of an n-point, 64-bit signed frame: bin 0 (the plain
// sum S0) and bin n/2 (the alternating sum SA). A frame is loaded slot by
// slot, then the bins are accumulated one slot per clock. Once finished, the
// sums, the overflow flags, the load count and (optionally) the max/min
// sample can be read back through a small register selector.
//
// Optional feature macro: FOURIER_MINMAX_EN
//   defined   -> max/min sample trackers are built and returned at addr 2
//   undefined -> no trackers, addr 2 reads back as zero
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low reset
//   operation  in   2   00 idle, 01 load, 10 compute, 11 readout
//   addr       in   32  slot index while loading, result selector on readout
//   x          in   64  signed sample, written while loading
//   y_re       out  64  registered readout, real / primary field
//   y_im       out  64  registered readout, imaginary / secondary field
//   done       out  1   high while computed results are valid
// ---------------------------------------------------------------------------
module fourier_bin_resp_64 #(
    parameter int n = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic        [1:0]  operation,
    input  logic        [31:0] addr,
    input  logic signed [63:0] x,
    output logic signed [63:0] y_re,
    output logic signed [63:0] y_im,
    output logic               done
);

    localparam int SW = (n > 1) ? $clog2(n) : 1;
    localparam int IW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic      [IW-1:0] r_idx;
    logic signed [63:0] r_slots [n];
    logic signed [63:0] r_s0;
    logic signed [63:0] r_sa;
    logic        [31:0] r_loadCount;
    logic               r_ovfSum;
    logic               r_ovfAlt;
`ifdef FOURIER_MINMAX_EN
    logic signed [63:0] r_max;
    logic signed [63:0] r_min;
`endif

    logic               w_writeEn;
    logic               w_startFrame;
    logic               w_accum;
    logic      [SW-1:0] w_rdIdx;
    logic signed [63:0] w_curX;
    logic signed [63:0] w_sumNext;
    logic signed [63:0] w_altNext;
    logic               w_sumOvf;
    logic               w_altOvf;
    logic signed [63:0] w_yRe;
    logic signed [63:0] w_yIm;

    // Sample writes are only honoured in IDLE/LOAD and only for valid slots.
    assign w_writeEn    = ((r_state == IDLE) || (r_state == LOAD)) &&
                          (operation == 2'b01) && (addr < 32'(n));
    assign w_startFrame = (r_state == IDLE) && (operation == 2'b01);
    // r_idx runs 0..n; the extra step at n is the cycle that moves to DONE,
    // which places done n+1 edges after the compute command is taken.
    assign w_accum      = (r_state == CALC) && (operation != 2'b00) &&
                          (r_idx < IW'(n));
    assign w_rdIdx      = (r_idx < IW'(n)) ? r_idx[SW-1:0] : '0;
    assign w_curX       = r_slots[w_rdIdx];

    // Odd slots are subtracted for the n/2 bin; overflow is the usual
    // same-sign-in, different-sign-out test on the effective operands.
    assign w_sumNext = r_s0 + w_curX;
    assign w_sumOvf  = (r_s0[63] == w_curX[63]) && (w_sumNext[63] != r_s0[63]);
    assign w_altNext = r_idx[0] ? (r_sa - w_curX) : (r_sa + w_curX);
    assign w_altOvf  = r_idx[0] ?
                       ((r_sa[63] != w_curX[63]) && (w_altNext[63] != r_sa[63])) :
                       ((r_sa[63] == w_curX[63]) && (w_altNext[63] != r_sa[63]));

    assign done = (r_state == DONE);

    // Next-state logic; operation 00 returns to IDLE from any state and
    // takes priority over completing a computation.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (operation == 2'b01) w_nextState = LOAD;
            LOAD: begin
                if (operation == 2'b00)      w_nextState = IDLE;
                else if (operation == 2'b10) w_nextState = CALC;
            end
            CALC: begin
                if (operation == 2'b00)       w_nextState = IDLE;
                else if (r_idx == IW'(n))     w_nextState = DONE;
            end
            DONE: if (operation == 2'b00) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Readout selector decode.
    always_comb begin
        w_yRe = '0;
        w_yIm = '0;
        case (addr)
            32'd0: w_yRe = r_s0;
            32'd1: w_yRe = r_sa;
            32'd2: begin
`ifdef FOURIER_MINMAX_EN
                w_yRe = r_max;
                w_yIm = r_min;
`endif
            end
            32'd3: begin
                w_yRe = {32'b0, r_loadCount};
                w_yIm = {62'b0, r_ovfAlt, r_ovfSum};
            end
            default: begin
                w_yRe = '0;
                w_yIm = '0;
            end
        endcase
    end

    // State register and slot index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state != CALC) r_idx <= '0;
            else if (w_accum)    r_idx <= r_idx + 1'b1;
        end
    end

    // Sample slots; unwritten slots keep their previous-frame contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < n; i++) r_slots[i] <= '0;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (w_writeEn && (addr == 32'(i))) r_slots[i] <= x;
            end
        end
    end

    // Accumulators, flags, load counter and readout registers. Starting a
    // frame clears everything and then counts that same cycle's write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0        <= '0;
            r_sa        <= '0;
            r_loadCount <= '0;
            r_ovfSum    <= 1'b0;
            r_ovfAlt    <= 1'b0;
            y_re        <= '0;
            y_im        <= '0;
`ifdef FOURIER_MINMAX_EN
            r_max       <= '0;
            r_min       <= '0;
`endif
        end else begin
            if (w_startFrame) begin
                r_s0        <= '0;
                r_sa        <= '0;
                r_ovfSum    <= 1'b0;
                r_ovfAlt    <= 1'b0;
                r_loadCount <= w_writeEn ? 32'd1 : 32'd0;
`ifdef FOURIER_MINMAX_EN
                r_max       <= '0;
                r_min       <= '0;
`endif
            end else if (w_writeEn && (r_loadCount != 32'hFFFF_FFFF)) begin
                r_loadCount <= r_loadCount + 32'd1;
            end

            if (w_accum) begin
                r_s0     <= w_sumNext;
                r_sa     <= w_altNext;
                r_ovfSum <= r_ovfSum | w_sumOvf;
                r_ovfAlt <= r_ovfAlt | w_altOvf;
`ifdef FOURIER_MINMAX_EN
                // Slot 0 seeds both trackers so stale values never leak in.
                if ((r_idx == '0) || (w_curX > r_max)) r_max <= w_curX;
                if ((r_idx == '0) || (w_curX < r_min)) r_min <= w_curX;
`endif
            end

            if ((r_state == DONE) && (operation == 2'b11)) begin
                y_re <= w_yRe;
                y_im <= w_yIm;
            end
        end
    end

endmodule

// File: tb/tb_fourier_bin_resp_64.sv
// ---------------------------------------------------------------------------
// tb_fourier_bin_resp_64
//
// Directed frames with hand-computed results. Readout requests push their
// expected y_re/y_im into a queue; a monitor pops and compares on every edge
// where a readout command was sampled. Latency, reset and abort behaviour
// are checked inline. Expectations follow FOURIER_MINMAX_EN when defined.
// ---------------------------------------------------------------------------
module tb_fourier_bin_resp_64;

    localparam int N = 10;
    localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic        [1:0]  operation = 2'b00;
    logic        [31:0] addr = '0;
    logic signed [63:0] x = '0;
    logic signed [63:0] y_re;
    logic signed [63:0] y_im;
    logic               done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] re;
        logic [63:0] im;
        int          tag;
    } exp_t;

    exp_t        expQ[$];
    logic [63:0] frameVals [N];

    fourier_bin_resp_64 #(.n(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .operation (operation),
        .addr      (addr),
        .x         (x),
        .y_re      (y_re),
        .y_im      (y_im),
        .done      (done)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Compare one value and report on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one command on the falling edge; the next rising edge samples it.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [63:0] xv);
        @(negedge clk);
        operation = op;
        addr      = a;
        x         = xv;
    endtask

    // Queue an expected readout and issue the readout command.
    task automatic readout(input logic [31:0] a, input logic [63:0] re,
                           input logic [63:0] im);
        exp_t e;
        e.re  = re;
        e.im  = im;
        e.tag = int'(a);
        expQ.push_back(e);
        applyStimulus(2'b11, a, '0);
    endtask

    // Write frameVals into all slots.
    task automatic loadFrame();
        for (int k = 0; k < N; k++) applyStimulus(2'b01, k, frameVals[k]);
    endtask

    // Issue compute and count edges from the sampling edge until done rises.
    task automatic computeAndWait(input string name);
        int edges;
        edges = 0;
        applyStimulus(2'b10, '0, '0);
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = c;
                break;
            end
        end
        checkOutput(name, edges, N + 1);
    endtask

    // Scoreboard monitor: every sampled readout command pops one entry.
    initial begin
        logic [1:0] op;
        exp_t       e;
        forever begin
            @(posedge clk);
            op = operation;
            #1;
            if (op == 2'b11) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedReadout actual=%0h required=none", y_re);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("readoutRe_addr%0d", e.tag), y_re, e.re);
                    checkOutput($sformatf("readoutIm_addr%0d", e.tag), y_im, e.im);
                end
            end
        end
    end

    initial begin
        int seen;

        // Reset state.
        #12;
        checkOutput("resetDone", done, 0);
        checkOutput("resetYre", y_re, 0);
        checkOutput("resetYim", y_im, 0);
        @(negedge clk);
        reset = 1'b1;

        // Frame A: x[k] = k+1. S0 = 55, SA = -5, max 10, min 1.
        for (int k = 0; k < N; k++) frameVals[k] = 64'(k + 1);
        loadFrame();
        computeAndWait("latencyA");
        readout(7, 0, 0);
        readout(1, -64'sd5, 0);
`ifdef FOURIER_MINMAX_EN
        readout(2, 64'd10, 64'd1);
`else
        readout(2, 0, 0);
`endif
        readout(3, 64'd10, 0);
        readout(0, 64'd55, 0);
        applyStimulus(2'b00, '0, '0);
        @(posedge clk);
        #1;
        checkOutput("doneLowAfterIdle", done, 0);

        // Frame B: all slots MAXV, plus an ignored write to slot 10, and a
        // readout in LOAD that must leave the outputs alone.
        // S0 = 10*MAXV wraps to -10 (overflow); SA alternates MAXV/0, no overflow.
        applyStimulus(2'b01, 0, MAXV);
        readout(1, 64'd55, 0);
        for (int k = 1; k <= N; k++) applyStimulus(2'b01, k, MAXV);
        computeAndWait("latencyB");
        readout(3, 64'd10, 64'd1);
        readout(1, 0, 0);
`ifdef FOURIER_MINMAX_EN
        readout(2, MAXV, MAXV);
`else
        readout(2, 0, 0);
`endif
        readout(0, -64'sd10, 0);

        // Frame C: x0 = MAXV, x1 = MINV, rest 0. S0 = -1 without overflow;
        // SA = MAXV - MINV overflows to -1.
        applyStimulus(2'b00, '0, '0);
        for (int k = 0; k < N; k++) frameVals[k] = '0;
        frameVals[0] = MAXV;
        frameVals[1] = MINV;
        loadFrame();
        computeAndWait("latencyC");
        readout(3, 64'd10, 64'd2);
        readout(1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
`ifdef FOURIER_MINMAX_EN
        readout(2, MAXV, MINV);
`else
        readout(2, 0, 0);
`endif
        readout(0, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // Reset in the middle of a computation clears outputs immediately.
        applyStimulus(2'b00, '0, '0);
        for (int k = 0; k < N; k++) frameVals[k] = 64'd7;
        loadFrame();
        applyStimulus(2'b10, '0, '0);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midCalcResetDone", done, 0);
        checkOutput("midCalcResetYre", y_re, 0);
        checkOutput("midCalcResetYim", y_im, 0);
        applyStimulus(2'b00, '0, '0);
        @(negedge clk);
        reset = 1'b1;

        // Frame D after reset: x[k] = 2. S0 = 20, SA = 0.
        for (int k = 0; k < N; k++) frameVals[k] = 64'd2;
        loadFrame();
        computeAndWait("latencyD");
        readout(1, 0, 0);
        readout(3, 64'd10, 0);
        readout(0, 64'd20, 0);

        // Abort during compute: done must never rise, IDLE readout holds.
        applyStimulus(2'b00, '0, '0);
        for (int k = 0; k < N; k++) frameVals[k] = 64'd5;
        loadFrame();
        applyStimulus(2'b10, '0, '0);
        repeat (3) @(posedge clk);
        applyStimulus(2'b00, '0, '0);
        seen = 0;
        repeat (N + 5) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        checkOutput("abortNoDone", seen, 0);
        readout(0, 64'd20, 0);

        // Frame E: x[k] = -3. S0 = -30, SA = 0, count 10.
        applyStimulus(2'b00, '0, '0);
        for (int k = 0; k < N; k++) frameVals[k] = -64'sd3;
        loadFrame();
        computeAndWait("latencyE");
        readout(3, 64'd10, 0);
        readout(1, 0, 0);
        readout(0, -64'sd30, 0);

        applyStimulus(2'b00, '0, '0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput("queueDrained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
